udp_rx_mport: RTL



---
 rtl/udp_rx_mport.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/udp_rx_mport.sv
// udp_rx_mport
//   UDP receive parser sitting between the IPv4 receive block and the
//   application. It strips the 8-byte UDP header and matches the destination
//   port against DST_PORTS. Matching payload is forwarded with the table index
//   on chan_o. Payload is cut at the UDP length, so IP padding never leaves
//   the block. Every output is registered, giving one cycle of latency.
//
// Optional feature (macro UDP_RX_LEN_CHECK_EN):
//   When defined, err_o is raised with term_o in two cases: the frame ended
//   before the UDP length was reached, or ip_cs_err_i was seen on a payload
//   beat. When undefined, err_o stays 0. Header-time drops behave the same in
//   both builds.
//
// Ports
//   clk, nreset      clock and asynchronous active-low reset
//   valid_i          input beat valid
//   start_i, term_i  first and last beat of the IP payload
//   len_i            valid bytes in the beat (KEEP_W except on term)
//   data_i           beat data; first byte in [7:0]
//   ip_cs_err_i      IPv4 header checksum error, valid on any beat
//   cancel_i         abort the current frame (qualified by valid_i)
//   valid_o, start_o, term_o, len_o, data_o   payload beat out
//   chan_o           index of the matched DST_PORTS entry
//   cancel_o         the forwarded frame was aborted
//   err_o            frame error, meaningful only with term_o
//
// Handshake: there is no backpressure. A beat is transferred on every cycle
// where valid_i is high. Each output beat appears exactly one cycle after its
// input beat, and valid_o is high for that one cycle only.
module udp_rx_mport #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = DATA_W / 8,
  parameter int LEN_W = $clog2(KEEP_W) + 1,
  parameter int PORT_N = 2,
  parameter int CHAN_W = (PORT_N > 1) ? $clog2(PORT_N) : 1,
  parameter logic [15:0] SRC_PORT = 16'd0,
  parameter logic [16*PORT_N-1:0] DST_PORTS = {16'd18071, 16'd18070}
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic              term_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ip_cs_err_i,
  input  logic              cancel_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              term_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CHAN_W-1:0] chan_o,
  output logic              cancel_o,
  output logic              err_o
);

`ifdef UDP_RX_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  localparam logic [3:0]  KEEP4     = 4'(KEEP_W);
  localparam logic [63:0] BEAT_MASK = 64'({DATA_W{1'b1}});

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    HEAD = 5'b00010,
    DATA = 5'b00100,
    PAD  = 5'b01000,
    DROP = 5'b10000
  } state_t;

  state_t      state;
  logic [3:0]  hcnt;      // header bytes collected so far
  logic [63:0] hdr_q;     // header bytes, byte k at [8k+7:8k]
  logic [15:0] rem;       // payload bytes still owed by the UDP length
  logic        first_q;   // next DATA beat is the first payload beat
  logic        cs_err_q;  // checksum error seen during payload

  // Header assembly: a start beat always lands at byte 0, so a restart in
  // the middle of a frame begins a fresh header.
  logic [3:0]  off;
  logic [63:0] hdr_next;
  logic        hdr_last;
  logic [15:0] src_port, dst_port, ulen;

  always_comb begin
    off      = start_i ? 4'd0 : hcnt;
    hdr_next = (hdr_q & ~(BEAT_MASK << {off, 3'b000})) |
               (64'(data_i) << {off, 3'b000});
    hdr_last = (off + KEEP4) >= 4'd8;
    src_port = {hdr_next[7:0],   hdr_next[15:8]};
    dst_port = {hdr_next[23:16], hdr_next[31:24]};
    ulen     = {hdr_next[39:32], hdr_next[47:40]};
  end

  // Port table lookup; scanning from the top down leaves the lowest
  // matching index in port_idx.
  logic              port_hit;
  logic [CHAN_W-1:0] port_idx;

  always_comb begin
    port_hit = 1'b0;
    port_idx = '0;
    for (int i = PORT_N - 1; i >= 0; i--) begin
      if (DST_PORTS[16*i +: 16] == dst_port) begin
        port_hit = 1'b1;
        port_idx = CHAN_W'(i);
      end
    end
  end

  logic src_ok, hdr_ok, rem_last, early, err_next;

  always_comb begin
    src_ok   = (SRC_PORT == 16'd0) || (src_port == SRC_PORT);
    // A header that ends with the IP payload (term_i) is too short to carry
    // any UDP payload, so it is dropped like a bad header.
    hdr_ok   = port_hit && src_ok && (ulen > 16'd8) && !ip_cs_err_i && !term_i;
    rem_last = rem <= 16'(KEEP_W);
    early    = term_i && !rem_last;
    err_next = LEN_CHECK && (early || cs_err_q || ip_cs_err_i);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      hcnt     <= '0;
      hdr_q    <= '0;
      rem      <= '0;
      first_q  <= 1'b0;
      cs_err_q <= 1'b0;
      valid_o  <= 1'b0;
      start_o  <= 1'b0;
      term_o   <= 1'b0;
      len_o    <= '0;
      data_o   <= '0;
      chan_o   <= '0;
      cancel_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      valid_o  <= 1'b0;
      start_o  <= 1'b0;
      term_o   <= 1'b0;
      cancel_o <= 1'b0;
      err_o    <= 1'b0;
      if (valid_i) begin
        if (cancel_i) begin
          // Cancel beats term_i on the same beat; only a frame already
          // being forwarded needs cancel_o.
          state    <= IDLE;
          cancel_o <= (state == DATA);
        end else if (start_i || state == HEAD) begin
          cancel_o <= start_i && (state == DATA);
          hdr_q    <= hdr_next;
          if (!hdr_last) begin
            hcnt  <= off + KEEP4;
            state <= (term_i || ip_cs_err_i) ? DROP : HEAD;
          end else if (hdr_ok) begin
            state    <= DATA;
            rem      <= ulen - 16'd8;
            chan_o   <= port_idx;
            first_q  <= 1'b1;
            cs_err_q <= 1'b0;
          end else begin
            state <= DROP;
          end
        end else begin
          case (state)
            DATA: begin
              valid_o  <= 1'b1;
              start_o  <= first_q;
              first_q  <= 1'b0;
              data_o   <= data_i;
              cs_err_q <= cs_err_q | ip_cs_err_i;
              if (rem_last) begin
                // UDP length reached; anything after this is IP padding.
                term_o <= 1'b1;
                len_o  <= rem[LEN_W-1:0];
                err_o  <= err_next;
                state  <= term_i ? IDLE : PAD;
              end else begin
                len_o <= len_i;
                rem   <= rem - 16'(KEEP_W);
                if (term_i) begin
                  term_o <= 1'b1;
                  err_o  <= err_next;
                  state  <= IDLE;
                end
              end
            end
            PAD, DROP: begin
              if (term_i) state <= IDLE;
            end
            default: ;  // IDLE: beats outside a frame are ignored
          endcase
        end
      end
    end
  end

endmodule
